bv_check_monitor: RTL and testbench

Parametrised runtime checker for bit-vector population-count rules (all-zero, one-hot-or-zero, one-hot, at-most-LIMIT) applied independently to CHANNELS lanes of WIDTH bits. Generalises our single-signal `$countones`/`$onehot0`/`$onehot` formal checks into synthesisable hardware with per-channel violation flags, sticky status, a saturating error counter and first-failure capture. It sits beside the monitored logic as a passive observer and feeds a status/debug register bank.

---
 rtl/bv_check_monitor.sv | 163 ++++++++++++++++
 tb/tb_bv_check_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bv_check_monitor.sv
// Passive population-count rule checker over CHANNELS lanes of WIDTH bits.
// Registers per-lane violations, sticky status, saturating counters and first-failure capture.
module bv_check_monitor #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int MODE     = 1,
    parameter int LIMIT    = 2,
    parameter int HOLDOFF  = 1,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         clr,
    input  logic [CHANNELS*WIDTH-1:0]    data,
    output logic [CHANNELS-1:0]          fail,
    output logic [CHANNELS-1:0]          sticky,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [CNT_W-1:0]             cyc_cnt,
    output logic                         first_valid,
    output logic [CH_W-1:0]              first_ch,
    output logic [CNT_W-1:0]             first_cyc
);

    localparam int OW = $clog2(WIDTH + 1);
    localparam int NW = $clog2(CHANNELS + 1);
    localparam int SW = ((CNT_W > NW) ? CNT_W : NW) + 1;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (WIDTH < 1 || CHANNELS < 1) begin : g_bad_size
        $error("bv_check_monitor: WIDTH and CHANNELS must be at least 1");
    end
    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("bv_check_monitor: MODE must be 0..3");
    end
    if (LIMIT < 0 || LIMIT > WIDTH) begin : g_bad_limit
        $error("bv_check_monitor: LIMIT must be 0..WIDTH");
    end

    typedef enum logic [1:0] {
        HOLD,
        ARM,
        TRIP
    } state_t;

    state_t              state, state_nxt;
    logic [HW-1:0]       hold_cnt;
    logic [CHANNELS-1:0] viol;
    logic [NW-1:0]       nfail;
    logic [CH_W-1:0]     low_ch;
    logic [SW-1:0]       err_sum;
    logic [CNT_W-1:0]    err_nxt;
    logic                checked;
    logic                do_clr;
    logic                capture;

    function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int b = 0; b < WIDTH; b++) begin
            n = n + OW'(v[b]);
        end
        return n;
    endfunction

    function automatic logic rule_violated(input logic [OW-1:0] ones);
        case (MODE)
            0:       return ones != '0;
            1:       return ones > OW'(1);
            2:       return ones != OW'(1);
            default: return ones > OW'(LIMIT);
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        viol   = '0;
        nfail  = '0;
        low_ch = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            viol[c] = rule_violated(popcount(data[c*WIDTH +: WIDTH]));
            nfail   = nfail + NW'(viol[c]);
        end
        // Scan downwards so the lowest failing lane is the last one written.
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (viol[c]) begin
                low_ch = CH_W'(c);
            end
        end
    end

    assign checked = en && (state != HOLD);
    assign do_clr  = checked && clr;
    assign capture = checked && !clr && (state == ARM) && (|viol);
    assign err_sum = SW'(err_cnt) + SW'(nfail);
    assign err_nxt = (err_sum > SW'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: if (en && hold_cnt == HW'(1)) state_nxt = ARM;
            ARM: begin
                if (do_clr) begin
                    state_nxt = ARM;
                end else if (capture) begin
                    state_nxt = TRIP;
                end
            end
            TRIP: if (do_clr) state_nxt = ARM;
            default: state_nxt = HOLD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= (HOLDOFF == 0) ? ARM : HOLD;
            hold_cnt <= HW'(HOLDOFF);
        end else begin
            state <= state_nxt;
            if (state == HOLD && en) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    // NOTE: every status register has an async reset value; there is no memory array to leave unreset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fail        <= '0;
            sticky      <= '0;
            err_cnt     <= '0;
            cyc_cnt     <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_cyc   <= '0;
        end else begin
            fail <= checked ? viol : '0;
            if (do_clr) begin
                sticky      <= '0;
                err_cnt     <= '0;
                cyc_cnt     <= '0;
                first_valid <= 1'b0;
                first_ch    <= '0;
                first_cyc   <= '0;
            end else if (checked) begin
                sticky  <= sticky | viol;
                err_cnt <= err_nxt;
                if (cyc_cnt != CNT_MAX) begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                end
                if (capture) begin
                    first_valid <= 1'b1;
                    first_ch    <= low_ch;
                    first_cyc   <= cyc_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bv_check_monitor.sv
// Randomised and directed bench for bv_check_monitor: four parameterisations
// checked against a behavioural popcount-rule model.
module tb_bv_check_monitor;

    localparam int N = 4;

    int    p_w[N]    = '{4, 4, 4, 8};
    int    p_mode[N] = '{1, 2, 0, 3};
    int    p_lim[N]  = '{2, 2, 2, 2};
    int    p_hold[N] = '{1, 1, 0, 3};
    int    p_cw[N]   = '{8, 8, 3, 8};
    string nm[N]     = '{"A", "B", "C", "D"};

    logic        clk;
    logic        rstn;
    logic        en;
    logic        clr;
    logic [15:0] dv[N];

    logic [1:0] fail_a, sticky_a, fail_b, sticky_b, fail_c, sticky_c, fail_d, sticky_d;
    logic [7:0] err_a, cyc_a, fcyc_a, err_b, cyc_b, fcyc_b, err_d, cyc_d, fcyc_d;
    logic [2:0] err_c, cyc_c, fcyc_c;
    logic       fv_a, fv_b, fv_c, fv_d;
    logic [0:0] fch_a, fch_b, fch_c, fch_d;

    int m_hold[N], m_trip[N], m_fail[N], m_sticky[N], m_err[N], m_cyc[N];
    int m_fv[N], m_fch[N], m_fcyc[N];

    int n_cmp = 0;
    int n_bad = 0;

    bv_check_monitor #(.WIDTH(4), .CHANNELS(2), .MODE(1), .LIMIT(2), .HOLDOFF(1), .CNT_W(8)) u_a (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .data(dv[0][7:0]),
        .fail(fail_a), .sticky(sticky_a), .err_cnt(err_a), .cyc_cnt(cyc_a),
        .first_valid(fv_a), .first_ch(fch_a), .first_cyc(fcyc_a));

    bv_check_monitor #(.WIDTH(4), .CHANNELS(2), .MODE(2), .LIMIT(2), .HOLDOFF(1), .CNT_W(8)) u_b (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .data(dv[1][7:0]),
        .fail(fail_b), .sticky(sticky_b), .err_cnt(err_b), .cyc_cnt(cyc_b),
        .first_valid(fv_b), .first_ch(fch_b), .first_cyc(fcyc_b));

    bv_check_monitor #(.WIDTH(4), .CHANNELS(2), .MODE(0), .LIMIT(2), .HOLDOFF(0), .CNT_W(3)) u_c (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .data(dv[2][7:0]),
        .fail(fail_c), .sticky(sticky_c), .err_cnt(err_c), .cyc_cnt(cyc_c),
        .first_valid(fv_c), .first_ch(fch_c), .first_cyc(fcyc_c));

    bv_check_monitor #(.WIDTH(8), .CHANNELS(2), .MODE(3), .LIMIT(2), .HOLDOFF(3), .CNT_W(8)) u_d (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .data(dv[3]),
        .fail(fail_d), .sticky(sticky_d), .err_cnt(err_d), .cyc_cnt(cyc_d),
        .first_valid(fv_d), .first_ch(fch_d), .first_cyc(fcyc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rule_bad(int mode, int limit, int ones);
        case (mode)
            0:       return ones != 0;
            1:       return ones > 1;
            2:       return ones != 1;
            default: return ones > limit;
        endcase
    endfunction

    task automatic model_reset_all();
        for (int i = 0; i < N; i++) begin
            m_hold[i] = p_hold[i];
            m_trip[i] = 0; m_fail[i] = 0; m_sticky[i] = 0; m_err[i] = 0;
            m_cyc[i] = 0; m_fv[i] = 0; m_fch[i] = 0; m_fcyc[i] = 0;
        end
    endtask

    task automatic model_step(int i, logic [15:0] d);
        int vmask, nv, lowc, maxc;
        maxc = (1 << p_cw[i]) - 1;
        if (!en) begin
            m_fail[i] = 0;
            return;
        end
        if (m_hold[i] > 0) begin
            m_hold[i]--;
            m_fail[i] = 0;
            return;
        end
        vmask = 0; nv = 0; lowc = -1;
        for (int c = 0; c < 2; c++) begin
            int lane = (int'(d) >> (c * p_w[i])) & ((1 << p_w[i]) - 1);
            if (rule_bad(p_mode[i], p_lim[i], $countones(lane))) begin
                vmask |= (1 << c);
                nv++;
                if (lowc < 0) lowc = c;
            end
        end
        m_fail[i] = vmask;
        if (clr) begin
            m_trip[i] = 0; m_sticky[i] = 0; m_err[i] = 0; m_cyc[i] = 0;
            m_fv[i] = 0; m_fch[i] = 0; m_fcyc[i] = 0;
            return;
        end
        m_sticky[i] |= vmask;
        m_err[i] = (m_err[i] + nv > maxc) ? maxc : m_err[i] + nv;
        if (m_trip[i] == 0 && vmask != 0) begin
            m_fv[i] = 1; m_fch[i] = lowc; m_fcyc[i] = m_cyc[i]; m_trip[i] = 1;
        end
        m_cyc[i] = (m_cyc[i] + 1 > maxc) ? maxc : m_cyc[i] + 1;
    endtask

    task automatic compare_inst(int i, int f, int s, int e, int c, int v, int ch, int fc);
        check({nm[i], ".fail"},        f,  m_fail[i]);
        check({nm[i], ".sticky"},      s,  m_sticky[i]);
        check({nm[i], ".err_cnt"},     e,  m_err[i]);
        check({nm[i], ".cyc_cnt"},     c,  m_cyc[i]);
        check({nm[i], ".first_valid"}, v,  m_fv[i]);
        check({nm[i], ".first_ch"},    ch, m_fch[i]);
        check({nm[i], ".first_cyc"},   fc, m_fcyc[i]);
    endtask

    task automatic compare_all();
        compare_inst(0, int'(fail_a), int'(sticky_a), int'(err_a), int'(cyc_a), int'(fv_a), int'(fch_a), int'(fcyc_a));
        compare_inst(1, int'(fail_b), int'(sticky_b), int'(err_b), int'(cyc_b), int'(fv_b), int'(fch_b), int'(fcyc_b));
        compare_inst(2, int'(fail_c), int'(sticky_c), int'(err_c), int'(cyc_c), int'(fv_c), int'(fch_c), int'(fcyc_c));
        compare_inst(3, int'(fail_d), int'(sticky_d), int'(err_d), int'(cyc_d), int'(fv_d), int'(fch_d), int'(fcyc_d));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rstn) begin
            for (int i = 0; i < N; i++) model_step(i, dv[i]);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        model_reset_all();
        #1 compare_all();
        cycle();
        rstn = 1'b1;
    endtask

    function automatic logic [15:0] rand_data(int w);
        logic [15:0] one;
        one = 16'h1;
        case ($urandom_range(0, 3))
            0:       return 16'h0;
            1:       return one << $urandom_range(0, 2 * w - 1);
            2:       return (one << $urandom_range(0, 2 * w - 1)) | (one << $urandom_range(0, 2 * w - 1));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rstn = 1'b0; en = 1'b0; clr = 1'b0;
        for (int i = 0; i < N; i++) dv[i] = 16'h0;
        model_reset_all();
        #1 compare_all();
        cycle();
        rstn = 1'b1;

        // Directed holdoff, first capture, saturation and MODE 3 boundary cases.
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dv[0] = (k < 2) ? 16'h0030 : 16'h0000;
            dv[1] = (k == 4) ? 16'h0000 : ((k == 5) ? 16'h0014 : 16'h0012);
            dv[2] = (k < 5) ? 16'h00FF : 16'h0000;
            dv[3] = (k == 3) ? 16'h0007 : ((k == 4) ? 16'h0081 : 16'h0000);
            cycle();
            if (k == 0) check("A.holdoff_fail", int'(fail_a), 0);
            if (k == 1) begin
                check("A.first_fail", int'(fail_a), 2);
                check("A.first_sticky", int'(sticky_a), 2);
                check("A.first_err", int'(err_a), 1);
                check("A.first_ch0", int'(fch_a), 1);
                check("A.first_cyc0", int'(fcyc_a), 0);
            end
            if (k == 3) check("D.limit_viol", int'(fail_d), 1);
            if (k == 4) begin
                check("B.zero_fail", int'(fail_b), 3);
                check("B.zero_err", int'(err_b), 2);
                check("B.zero_ch", int'(fch_b), 0);
                check("B.zero_cyc", int'(fcyc_b), 3);
                check("C.sat_err", int'(err_c), 7);
                check("C.sat_cyc", int'(cyc_c), 5);
                check("D.limit_ok", int'(fail_d), 0);
            end
            if (k == 5) begin
                check("B.recover_fail", int'(fail_b), 0);
                check("B.recover_sticky", int'(sticky_b), 3);
            end
        end

        // clr beats a simultaneous violation in TRIP, then recapture.
        clr = 1'b1;
        dv[0] = 16'h0030; dv[1] = 16'h0; dv[2] = 16'h0; dv[3] = 16'h0;
        cycle();
        check("A.clr_sticky", int'(sticky_a), 0);
        check("A.clr_err", int'(err_a), 0);
        check("A.clr_fv", int'(fv_a), 0);
        check("A.clr_fail", int'(fail_a), 2);
        clr = 1'b0;
        dv[0] = 16'h0003;
        cycle();
        check("A.recap_fv", int'(fv_a), 1);
        check("A.recap_ch", int'(fch_a), 0);
        check("A.recap_cyc", int'(fcyc_a), 0);

        // Disabled cycles with illegal data change nothing but fail.
        en = 1'b0;
        for (int i = 0; i < N; i++) dv[i] = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("A.dis_fail", int'(fail_a), 0);
            check("A.dis_cyc", int'(cyc_a), 1);
            check("A.dis_err", int'(err_a), 1);
        end

        // Reset mid-TRIP clears outputs at once; holdoff survives en=0.
        en = 1'b1;
        #2 rstn = 1'b0;
        model_reset_all();
        #1;
        check("A.rst_fail", int'(fail_a), 0);
        check("A.rst_sticky", int'(sticky_a), 0);
        check("A.rst_err", int'(err_a), 0);
        check("A.rst_fv", int'(fv_a), 0);
        compare_all();
        cycle();
        rstn = 1'b1;
        en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        en = 1'b1;
        dv[0] = 16'h0030;
        cycle();
        check("A.rehold_fail", int'(fail_a), 0);
        cycle();
        check("A.rearm_fail", int'(fail_a), 2);
        check("A.rearm_cyc", int'(fcyc_a), 0);

        // Randomised phase against the model.
        for (int t = 0; t < 1500; t++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = en && ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) dv[i] = rand_data(p_w[i]);
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
